// File: rtl/xsram_ctrl.sv
// External SRAM controller: splits 1/2/4-byte bus accesses into 8- or 16-bit
// SRAM beats, with registered strobes and a configurable number of wait states.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_1B
`define BUS_ACC_1B 2'b00
`endif
`ifndef BUS_ACC_2B
`define BUS_ACC_2B 2'b01
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'b10
`endif
`ifndef IOR_DIR_OUT
`define IOR_DIR_OUT 1'b1
`endif
`ifndef IOR_DIR_IN
`define IOR_DIR_IN 1'b0
`endif

module xsram_ctrl #(
    parameter int ADDR_WIDTH  = 19,
    parameter int PORT_WIDTH  = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                                     clk,
    input  logic                                     rstn,
    input  logic [ADDR_WIDTH-1:0]                    addr,
    input  logic                                     w_rb,
    input  logic [`BUS_ACC_WIDTH-1:0]                acc,
    input  logic [`BUS_WIDTH-1:0]                    wdata,
    input  logic                                     req,
    output logic [`BUS_WIDTH-1:0]                    rdata,
    output logic                                     resp,
    output logic                                     fault,
    output logic                                     sram_ce_bar,
    output logic                                     sram_oe_bar,
    output logic                                     sram_we_bar,
    output logic [PORT_WIDTH/8-1:0]                  sram_be_bar,
    output logic                                     sram_data_dir,
    input  logic [PORT_WIDTH-1:0]                    sram_data_in,
    output logic [PORT_WIDTH-1:0]                    sram_data_out,
    output logic [ADDR_WIDTH-((PORT_WIDTH==16)?1:0)-1:0] sram_addr
);
    localparam int PB     = PORT_WIDTH / 8;
    localparam int LOG2PB = (PB == 2) ? 1 : 0;
    localparam int SAW    = ADDR_WIDTH - LOG2PB;
    localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_DONE} state_t;

    state_t                    r_state, w_nState;
    logic [1:0]                r_beat, w_nBeat, w_lastIdx;
    logic [2:0]                r_wcnt, w_nWcnt;
    logic [ADDR_WIDTH-1:0]     r_addr, w_selAddr;
    logic                      r_wrb, w_selWrb;
    logic [`BUS_ACC_WIDTH-1:0] r_acc, w_selAcc;
    logic [`BUS_WIDTH-1:0]     r_wdata, w_selWdata, r_rbuf, w_rbufNext;
    logic                      w_valid, w_accept, w_capture, w_lastBeat, w_inAcc;
    logic [PB-1:0]             w_nBe;
    logic [PORT_WIDTH-1:0]     w_nDout, w_laneData;
    logic [SAW-1:0]            w_nSramAddr;

    always_comb begin
        case (acc)
            `BUS_ACC_1B: w_valid = 1'b1;
            `BUS_ACC_2B: w_valid = ~addr[0];
            `BUS_ACC_4B: w_valid = (addr[1:0] == 2'b00);
            default:     w_valid = 1'b0;
        endcase
    end

    assign fault = req & ~w_valid;

    always_comb begin
        case (r_acc)
            `BUS_ACC_2B: w_lastIdx = (PB == 1) ? 2'd1 : 2'd0;
            `BUS_ACC_4B: w_lastIdx = (PB == 1) ? 2'd3 : 2'd1;
            default:     w_lastIdx = 2'd0;
        endcase
    end

    assign w_lastBeat = (r_beat == w_lastIdx);

    // Reads skip SETUP/HOLD; writes frame each strobe so addr/data stay stable around we.
    always_comb begin
        w_nState  = r_state;
        w_nBeat   = r_beat;
        w_nWcnt   = r_wcnt;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_nState = S_IDLE;
                if (req && w_valid) begin
                    w_accept = 1'b1;
                    w_nState = w_rb ? S_SETUP : S_STROBE;
                    w_nBeat  = 2'd0;
                    w_nWcnt  = 3'd0;
                end
            end
            S_SETUP: begin
                w_nState = S_STROBE;
                w_nWcnt  = 3'd0;
            end
            S_STROBE: begin
                if (r_wcnt != WAIT_LAST) begin
                    w_nWcnt = r_wcnt + 3'd1;
                end else if (r_wrb) begin
                    w_nState = S_HOLD;
                end else begin
                    w_capture = 1'b1;
                    w_nWcnt   = 3'd0;
                    if (w_lastBeat) begin
                        w_nState = S_DONE;
                    end else begin
                        w_nBeat = r_beat + 2'd1;
                    end
                end
            end
            S_HOLD: begin
                if (w_lastBeat) begin
                    w_nState = S_DONE;
                end else begin
                    w_nState = S_SETUP;
                    w_nBeat  = r_beat + 2'd1;
                end
            end
            default: w_nState = S_IDLE;
        endcase
    end

    assign w_selAddr  = w_accept ? addr  : r_addr;
    assign w_selWrb   = w_accept ? w_rb  : r_wrb;
    assign w_selAcc   = w_accept ? acc   : r_acc;
    assign w_selWdata = w_accept ? wdata : r_wdata;
    assign w_inAcc    = (w_nState == S_SETUP) || (w_nState == S_STROBE) || (w_nState == S_HOLD);

    // Outputs are computed from next-state so the registered pins line up with the state.
    always_comb begin
        w_nBe       = '0;
        w_nDout     = '0;
        w_nSramAddr = sram_addr;
        if (!w_inAcc) begin
            w_nBe = '1;
        end else begin
            w_nSramAddr = SAW'(w_selAddr >> LOG2PB) + SAW'(w_nBeat);
            if (PB == 2 && w_selAcc == `BUS_ACC_1B) begin
                w_nBe = w_selAddr[0] ? PB'(2'b01) : PB'(2'b10);
            end
            if (w_selWrb) begin
                if (PB == 2 && w_selAcc == `BUS_ACC_1B) begin
                    w_nDout = PORT_WIDTH'({w_selWdata[7:0], w_selWdata[7:0]});
                end else begin
                    w_nDout = PORT_WIDTH'(w_selWdata >> (int'(w_nBeat) * PORT_WIDTH));
                end
            end
        end
    end

    // A single byte on a 16-bit port lives in lane addr[0] but lands in rdata byte 0.
    always_comb begin
        w_laneData = sram_data_in;
        if (PB == 2 && r_acc == `BUS_ACC_1B) begin
            w_laneData = PORT_WIDTH'(r_addr[0] ? sram_data_in[PORT_WIDTH-1 -: 8] : sram_data_in[7:0]);
        end
    end

    assign w_rbufNext = r_rbuf | (`BUS_WIDTH'(w_laneData) << (int'(r_beat) * PORT_WIDTH));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state       <= S_IDLE;
            r_beat        <= 2'd0;
            r_wcnt        <= 3'd0;
            r_addr        <= '0;
            r_wrb         <= 1'b0;
            r_acc         <= `BUS_ACC_1B;
            r_wdata       <= '0;
            r_rbuf        <= '0;
            rdata         <= '0;
            resp          <= 1'b0;
            sram_addr     <= '0;
            sram_ce_bar   <= 1'b1;
            sram_oe_bar   <= 1'b1;
            sram_we_bar   <= 1'b1;
            sram_be_bar   <= '1;
            sram_data_dir <= `IOR_DIR_IN;
            sram_data_out <= '0;
        end else begin
            r_state <= w_nState;
            r_beat  <= w_nBeat;
            r_wcnt  <= w_nWcnt;
            if (w_accept) begin
                r_addr  <= addr;
                r_wrb   <= w_rb;
                r_acc   <= acc;
                r_wdata <= wdata;
                r_rbuf  <= '0;
            end else if (w_capture) begin
                r_rbuf <= w_rbufNext;
            end
            if (w_capture && w_lastBeat) begin
                rdata <= w_rbufNext;
            end
            resp          <= (w_nState == S_DONE);
            sram_addr     <= w_nSramAddr;
            sram_ce_bar   <= ~w_inAcc;
            sram_oe_bar   <= ~((w_nState == S_STROBE) && !w_selWrb);
            sram_we_bar   <= ~((w_nState == S_STROBE) && w_selWrb);
            sram_be_bar   <= w_nBe;
            sram_data_dir <= (w_inAcc && w_selWrb) ? `IOR_DIR_OUT : `IOR_DIR_IN;
            sram_data_out <= w_nDout;
        end
    end

endmodule

// File: doc/xsram_ctrl.md
XSRAM_CTRL -- requirements
Module: xsram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 19, byte-address width of addr.
REQ-002 SHALL have parameter PORT_WIDTH, default 8, external data width; legal values 8 and 16 only. PB = PORT_WIDTH/8.
REQ-003 SHALL have parameter WAIT_CYCLES, default 0, extra strobe cycles per beat; legal range 0..7.
REQ-004 clk  input  1  clock, <100 MHz.
REQ-005 rstn  input  1  reset: synchronous, active-low, sampled on clk rising edge.
REQ-006 addr  input  ADDR_WIDTH  request byte address.
REQ-007 w_rb  input  1  1 = write, 0 = read.
REQ-008 acc  input  `BUS_ACC_WIDTH  access size: `BUS_ACC_1B, `BUS_ACC_2B or `BUS_ACC_4B.
REQ-009 wdata  input  `BUS_WIDTH  write data, little-endian.
REQ-010 req  input  1  request strobe, one cycle.
REQ-011 rdata  output  `BUS_WIDTH  read data, registered.
REQ-012 resp  output  1  completion pulse, registered.
REQ-013 fault  output  1  combinational request rejection.
REQ-014 sram_ce_bar, sram_oe_bar, sram_we_bar  output  1 each  registered SRAM strobes, active-low.
REQ-015 sram_be_bar  output  PB  registered byte-lane enables, active-low; lane 0 = bits [7:0].
REQ-016 sram_data_dir  output  1  `IOR_DIR_OUT or `IOR_DIR_IN.
REQ-017 sram_data_in / sram_data_out  input / output  PORT_WIDTH  SRAM data bus.
REQ-018 sram_addr  output  ADDR_WIDTH-log2(PB)  SRAM word address, registered.

Function
REQ-019 Invalid request: acc not one of the three codes, or addr not aligned to the access size (2B: addr[0]=0; 4B: addr[1:0]=0); fault = req & invalid in any state; an invalid request SHALL never be accepted.
REQ-020 Valid req SHALL be accepted only in IDLE or DONE; req in any other state SHALL be ignored, with no fault and no side effect.
REQ-021 On acceptance, addr, w_rb, acc and wdata SHALL be latched; later input changes SHALL have no effect.
REQ-022 Beat count N = max(1, bytes/PB), where bytes = 1, 2 or 4. Beat k SHALL address word (addr>>log2(PB))+k and carry access bytes k*PB..k*PB+PB-1.
REQ-023 Byte lanes: a 1B access on a 16-bit port SHALL enable only lane addr[0]; all other beats SHALL enable all lanes. sram_be_bar = all-ones outside an access.
REQ-024 States: IDLE, SETUP, STROBE, HOLD, DONE; transitions as below.
REQ-025 Read beat: STROBE for 1+WAIT_CYCLES cycles; enabled lanes SHALL be captured into rdata on the last STROBE edge.
REQ-026 Write beat: SETUP for 1 cycle, then STROBE for 1+WAIT_CYCLES cycles, then HOLD for 1 cycle.
REQ-027 After the last beat the block SHALL enter DONE for exactly one cycle, with resp=1 in that cycle, then go to IDLE unless a new request is accepted.
REQ-028 Latency: with acceptance edge at the end of cycle 0, resp SHALL be high in cycle N*(1+W)+1 for reads and cycle N*(3+W)+1 for writes (W = WAIT_CYCLES).
REQ-029 sram_ce_bar SHALL be 0 in SETUP, STROBE and HOLD only.
REQ-030 sram_oe_bar SHALL be 0 only in read STROBE.
REQ-031 sram_we_bar SHALL be 0 only in write STROBE, so address and data are stable one cycle before and after the we pulse.
REQ-032 sram_data_dir SHALL be `IOR_DIR_OUT only in write SETUP, STROBE and HOLD.
REQ-033 sram_data_out SHALL hold the current beat's bytes in those write states.
REQ-034 On read resp, rdata bytes at and above the access size SHALL be 0; byte i SHALL come from address addr+i.
REQ-035 rdata SHALL hold its value until the next read resp; writes SHALL not alter rdata.

Reset
REQ-036 While rstn=0 at an edge, the block SHALL go to IDLE and set resp=0, rdata=0, sram_addr=0, ce/oe/we_bar=1, be_bar=all-ones, data_dir=`IOR_DIR_IN.
REQ-037 Reset mid-access SHALL abort the access; sram_we_bar SHALL be 1 after that same edge, and no resp SHALL be issued for the aborted request.

Verification
REQ-038 PW=8, W=0, 4B read @0x100, SRAM bytes 11,22,33,44 -> sram_addr 0x100..0x103 in cycles 1-4, resp in cycle 5, rdata=0x44332211.
REQ-039 PW=8, W=2, 1B write 0xA5 @0x7 -> we_bar low in cycles 2-4 only, data_out=0xA5 in cycles 1-5, resp in cycle 6.
REQ-040 PW=16, W=0, 1B read @0x3 -> sram_addr=0x1, be_bar=2'b01, rdata=0x000000XX (upper byte of the word), resp in cycle 2.
REQ-041 2B req @0x1 and 4B req @0x2 -> fault=1 in the same cycle, no state change, resp stays 0.
REQ-042 Back-to-back: new valid req in the DONE cycle -> accepted, no IDLE gap; req during STROBE -> ignored.
REQ-043 rstn low during write STROBE -> we_bar=1 after that edge, no resp, next request completes normally.
